alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_iter.sv | 79 +++++++
 rtl/alu_mc.sv | 159 +++++++++++++++
 tb/tb_alu_mc.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: function codes, control states,
// and the value returned for reserved function codes.
package alu_pkg;

    localparam logic [3:0] FN_ADD    = 4'b0000;
    localparam logic [3:0] FN_SUB    = 4'b0001;
    localparam logic [3:0] FN_SRL    = 4'b0010;
    localparam logic [3:0] FN_SRA    = 4'b0011;
    localparam logic [3:0] FN_SLL    = 4'b0100;
    localparam logic [3:0] FN_AND    = 4'b0101;
    localparam logic [3:0] FN_OR     = 4'b0110;
    localparam logic [3:0] FN_XOR    = 4'b0111;
    localparam logic [3:0] FN_SLT    = 4'b1000;
    localparam logic [3:0] FN_SLTU   = 4'b1001;
    localparam logic [3:0] FN_MUL    = 4'b1100;
    localparam logic [3:0] FN_MULH   = 4'b1101;
    localparam logic [3:0] FN_MULHSU = 4'b1110;
    localparam logic [3:0] FN_MULHU  = 4'b1111;

    // Widest legal XLEN is 64; callers truncate with an explicit cast.
    localparam logic [63:0] RSVD_RESULT = 64'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    // All multiply functions share the 11xx prefix.
    function automatic logic is_mul_func(input logic [3:0] f);
        return f[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, XLEN cycles.
// Signed operands are converted to magnitudes up front and the product is
// negated on the final cycle, so the most-negative value needs no special case.
module alu_mul_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_flush,
    input  logic              i_start,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    input  logic              i_a_signed,
    input  logic              i_b_signed,
    output logic              o_done_c,
    output logic [2*XLEN-1:0] o_product_c
);

    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN);

    logic             r_run;
    logic             r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [XLEN-1:0]  r_mplier;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic [PW-1:0]    w_acc_nxt;

    // Operand magnitudes; 2's-complement negation of the most-negative value
    // yields the correct unsigned magnitude.
    assign w_a_neg = i_a_signed & i_a[XLEN-1];
    assign w_b_neg = i_b_signed & i_b[XLEN-1];
    assign w_a_mag = w_a_neg ? (~i_a + XLEN'(1)) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + XLEN'(1)) : i_b;

    // Partial product after consuming the current multiplier bit.
    assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done_c    = r_run && (r_cnt == CNT_W'(XLEN - 1));
    assign o_product_c = r_neg ? (~w_acc_nxt + PW'(1)) : w_acc_nxt;

    // Iteration state: load on start, shift-add while running, clear on flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run    <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_flush) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= PW'(w_a_mag);
            r_mplier <= w_b_mag;
        end else if (r_run) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (o_done_c) begin
                r_run <= 1'b0;
                r_acc <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle functions return one edge after accept; multiply functions
// iterate for XLEN cycles and exist only when ALU_MC_MUL_EN is defined
// (otherwise 11xx behaves as a reserved single-cycle function).
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [3:0]      func,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    logic [XLEN-1:0]    r_out;
    logic               r_out_valid;
    logic [XLEN-1:0]    w_out_nxt;
    logic               w_valid_nxt;
    logic [XLEN-1:0]    w_alu;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_accept;

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign w_shamt   = in2[SHAMT_W-1:0];
    assign w_accept  = in_valid && in_ready;

    // Single-cycle result for the current operands.
    always_comb begin
        w_alu = XLEN'(RSVD_RESULT);
        case (func)
            FN_ADD:  w_alu = in1 + in2;
            FN_SUB:  w_alu = in1 - in2;
            FN_SRL:  w_alu = in1 >> w_shamt;
            FN_SRA:  w_alu = XLEN'($signed(in1) >>> w_shamt);
            FN_SLL:  w_alu = in1 << w_shamt;
            FN_AND:  w_alu = in1 & in2;
            FN_OR:   w_alu = in1 | in2;
            FN_XOR:  w_alu = in1 ^ in2;
            FN_SLT:  w_alu = XLEN'($signed(in1) < $signed(in2));
            FN_SLTU: w_alu = XLEN'(in1 < in2);
            default: w_alu = XLEN'(RSVD_RESULT);
        endcase
    end

`ifdef ALU_MC_MUL_EN
    alu_state_e        r_state;
    alu_state_e        w_state_nxt;
    logic              r_mul_lo;
    logic              w_start_c;
    logic              w_done_c;
    logic [2*XLEN-1:0] w_product_c;
    logic              w_a_signed;
    logic              w_b_signed;

    assign w_a_signed = (func == FN_MULH) || (func == FN_MULHSU);
    assign w_b_signed = (func == FN_MULH);
    assign in_ready   = (r_state == ST_IDLE) && (!r_out_valid || out_ready) && !flush;
    assign busy       = (r_state == ST_MUL);

    alu_mul_iter #(
        .XLEN (XLEN)
    ) u_mul (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (flush),
        .i_start     (w_start_c),
        .i_a         (in1),
        .i_b         (in2),
        .i_a_signed  (w_a_signed),
        .i_b_signed  (w_b_signed),
        .o_done_c    (w_done_c),
        .o_product_c (w_product_c)
    );

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Remember whether the running multiply returns the low or high half.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mul_lo <= 1'b0;
        end else if (w_start_c) begin
            r_mul_lo <= (func == FN_MUL);
        end
    end
`else
    assign in_ready = (!r_out_valid || out_ready) && !flush;
    assign busy     = 1'b0;
`endif

    // Next state, multiplier start, and next result/valid.
    always_comb begin
        w_out_nxt   = r_out;
        w_valid_nxt = r_out_valid;
`ifdef ALU_MC_MUL_EN
        w_state_nxt = r_state;
        w_start_c   = 1'b0;
`endif
        if (flush) begin
            w_valid_nxt = 1'b0;
`ifdef ALU_MC_MUL_EN
            w_state_nxt = ST_IDLE;
`endif
        end else begin
            if (r_out_valid && out_ready) begin
                w_valid_nxt = 1'b0;
            end
`ifdef ALU_MC_MUL_EN
            if (w_accept && is_mul_func(func)) begin
                w_start_c   = 1'b1;
                w_state_nxt = ST_MUL;
            end else if (w_accept) begin
                w_out_nxt   = w_alu;
                w_valid_nxt = 1'b1;
            end
            if ((r_state == ST_MUL) && w_done_c) begin
                w_out_nxt   = r_mul_lo ? w_product_c[XLEN-1:0] : w_product_c[2*XLEN-1:XLEN];
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_IDLE;
            end
`else
            if (w_accept) begin
                w_out_nxt   = w_alu;
                w_valid_nxt = 1'b1;
            end
`endif
        end
    end

    // Registered result and its valid flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out       <= w_out_nxt;
            r_out_valid <= w_valid_nxt;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit instance driven through a result scoreboard and
// an 8-bit instance checked directly. Multiply scenarios follow ALU_MC_MUL_EN.
module tb_alu_mc;

    localparam logic [3:0] F_ADD = 4'h0, F_SUB = 4'h1, F_SRL = 4'h2, F_SRA = 4'h3;
    localparam logic [3:0] F_SLL = 4'h4, F_AND = 4'h5, F_OR = 4'h6, F_XOR = 4'h7;
    localparam logic [3:0] F_SLT = 4'h8, F_SLTU = 4'h9;
    localparam logic [3:0] F_MUL = 4'hC, F_MULH = 4'hD, F_MULHSU = 4'hE, F_MULHU = 4'hF;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  func;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in1_8;
    logic [7:0]  in2_8;
    logic [3:0]  func8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  out8;
    logic        busy8;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    logic [31:0] stg_exp;
    bit          stg_push;

    alu_mc #(.XLEN(32)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .func(func),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .busy(busy)
    );

    alu_mc #(.XLEN(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in1(in1_8), .in2(in2_8), .func(func8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, 32-bit operands.
    function automatic logic [31:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] r;
`ifdef ALU_MC_MUL_EN
        logic [63:0] p;
`endif
        sh = b[4:0];
        r  = 32'd0;
        case (f)
            F_ADD:  r = a + b;
            F_SUB:  r = a + (~b) + 32'd1;
            F_SRL:  r = a >> sh;
            F_SRA:  begin
                        r = a >> sh;
                        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                    end
            F_SLL:  r = a << sh;
            F_AND:  r = a & b;
            F_OR:   r = a | b;
            F_XOR:  r = a ^ b;
            F_SLT:  r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
            F_SLTU: r = {31'd0, (a < b)};
`ifdef ALU_MC_MUL_EN
            F_MUL:    begin p = {32'd0, a} * {32'd0, b};             r = p[31:0];  end
            F_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            F_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b};       r = p[63:32]; end
            F_MULHU:  begin p = {32'd0, a} * {32'd0, b};             r = p[63:32]; end
`endif
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // One clock: retire/accept bookkeeping just before the edge, return at edge+1.
    task automatic step();
        logic [31:0] e;
        #1;
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: out=%h retired with nothing expected", out);
            end else begin
                e = exp_q.pop_front();
                if (out !== e) begin
                    errors++;
                    $display("FAIL sb_result: out=%h expected %h", out, e);
                end
            end
        end
        if (reset_n && in_valid && in_ready && stg_push) exp_q.push_back(stg_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input bit push);
        in_valid = 1'b1; func = f; in1 = a; in2 = b;
        stg_exp = e; stg_push = push;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b expected 1 (func=%h)", in_ready, f);
        end
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        stg_push = 1'b0;
    endtask

    task automatic wait_out(input int maxc);
        int n;
        n = 0;
        while (!out_valid && n < maxc) begin
            step();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_out_timeout: out_valid=%b after %0d cycles", out_valid, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in1 = '0; in2 = '0; func = '0; stg_push = 1'b0; stg_exp = '0;
        in_valid8 = 1'b0; in1_8 = '0; in2_8 = '0; func8 = '0; out_ready8 = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: %b expected 0", out_valid); end
        if (out !== 32'd0)      begin errors++; $display("FAIL reset_out: %h expected 0", out); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: %b expected 0", busy); end
        if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: %b expected 0", out_valid8); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0]  df [13] = '{F_ADD, F_SUB, F_SRA, F_SLT, F_SLTU, F_SRL, F_SLL,
                                 F_AND, F_OR, F_XOR, 4'hA, 4'hB, F_SLT};
        logic [31:0] da [13] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h1, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                                 32'h1234_5678, 32'h1234_5678, 32'h1};
        logic [31:0] db [13] = '{32'h1, 32'h1, 32'h21, 32'h1, 32'h1, 32'h21, 32'h3F,
                                 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'h1, 32'h9, 32'hFFFF_FFFF};
        logic [31:0] de [13] = '{32'h0, 32'hFFFF_FFFF, 32'hC000_0000, 32'h1, 32'h0, 32'h4000_0000,
                                 32'h8000_0000, 32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0,
                                 32'h0, 32'h0, 32'h0};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            send(df[i], da[i], db[i], de[i], 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out !== de[i]) begin
                errors++;
                $display("FAIL single_%0d: out_valid=%b out=%h expected 1/%h", i, out_valid, out, de[i]);
            end
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            f = 4'($urandom_range(0, 11));
            a = $urandom;
            b = (i % 3 == 0) ? a : $urandom;
            send(f, a, b, model(f, a, b), 1'b1);
        end
        idle();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(F_ADD, 32'd5, 32'd6, 32'd11, 1'b1);
        in_valid = 1'b1; func = F_SUB; in1 = 32'd20; in2 = 32'd3;
        stg_exp = 32'd17; stg_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out !== 32'd11 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: out_valid=%b out=%h in_ready=%b expected 1/0000000b/0",
                         i, out_valid, out, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: %b expected 1", in_ready); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 32'd17) begin
            errors++;
            $display("FAIL stall_next: out_valid=%b out=%h expected 1/00000011", out_valid, out);
        end
        idle();
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid = 1'b1; func = F_ADD; in1 = 32'd1; in2 = 32'd1;
        stg_exp = 32'd2; stg_push = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: in_ready=%b expected 0", in_ready); end
        step();
        flush = 1'b0;
        idle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept: out_valid=%b expected 0", out_valid); end
        out_ready = 1'b0;
        send(F_ADD, 32'd7, 32'd8, 32'd15, 1'b0);
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_pending: out_valid=%b expected 0", out_valid); end
        step();
    endtask

`ifdef ALU_MC_MUL_EN
    task automatic test_mul();
        int n;
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        out_ready = 1'b1;
        send(F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
        idle();
        n = 0;
        while (busy && n < 100) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mul_busy_cycle_%0d: in_ready=%b out_valid=%b expected 0/0", n, in_ready, out_valid);
            end
            step();
            n++;
        end
        checks++;
        if (n != 32 || out_valid !== 1'b1 || out !== 32'h4000_0000) begin
            errors++;
            $display("FAIL mulh_minneg: busy_cycles=%0d out_valid=%b out=%h expected 32/1/40000000", n, out_valid, out);
        end
        step();
        send(F_MULHSU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 1'b1);         idle(); wait_out(100); step();
        send(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1); idle(); wait_out(100); step();
        send(F_MUL, 32'h8000_0001, 32'h3, 32'h8000_0003, 1'b1);           idle(); wait_out(100); step();
        for (int i = 0; i < 8; i++) begin
            f = 4'($urandom_range(12, 15));
            a = (i == 0) ? 32'h8000_0000 : $urandom;
            b = $urandom;
            send(f, a, b, model(f, a, b), 1'b1);
            idle();
            wait_out(100);
            step();
        end
    endtask

    task automatic test_mul_abort();
        int seen;
        out_ready = 1'b1;
        seen = 0;
        send(F_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0);
        idle();
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_flush: busy=%b out_valid=%b expected 0/0", busy, out_valid);
        end
        send(F_ADD, 32'd1, 32'd2, 32'd3, 1'b1);
        idle();
        step();
        send(F_MULHU, 32'hFFFF_0000, 32'hFFFF, 32'h0, 1'b0);
        idle();
        repeat (9) step();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out !== 32'd0) begin
            errors++;
            $display("FAIL mul_reset: busy=%b out_valid=%b out=%h expected 0/0/0", busy, out_valid, out);
        end
        reset_n = 1'b1;
        send(F_ADD, 32'd4, 32'd5, 32'd9, 1'b1);
        idle();
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            step();
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL mul_abort_quiet: out_valid cycles=%0d expected 1", seen);
        end
    endtask
`else
    task automatic test_mul_reserved();
        int hi;
        hi = 0;
        out_ready = 1'b1;
        for (int i = 12; i < 16; i++) begin
            send(4'(i), 32'h8000_0003, 32'h7, 32'h0, 1'b1);
            if (busy) hi++;
            checks++;
            if (out_valid !== 1'b1 || out !== 32'd0) begin
                errors++;
                $display("FAIL mul_reserved_%0d: out_valid=%b out=%h expected 1/0", i, out_valid, out);
            end
        end
        idle();
        step();
        if (busy) hi++;
        checks++;
        if (hi != 0) begin errors++; $display("FAIL mul_reserved_busy: busy seen %0d times expected 0", hi); end
    endtask
`endif

    task automatic test_xlen8();
        in_valid8 = 1'b1; func8 = F_ADD; in1_8 = 8'h7F; in2_8 = 8'h01;
        #1;
        checks++;
        if (in_ready8 !== 1'b1) begin errors++; $display("FAIL x8_ready: in_ready=%b expected 1", in_ready8); end
        step();
        checks++;
        if (out_valid8 !== 1'b1 || out8 !== 8'h80) begin
            errors++;
            $display("FAIL x8_add: out_valid=%b out=%h expected 1/80", out_valid8, out8);
        end
`ifdef ALU_MC_MUL_EN
        func8 = F_MULHU; in1_8 = 8'hFF; in2_8 = 8'hFF;
        step();
        in_valid8 = 1'b0;
        begin
            int n;
            n = 0;
            while (busy8 && n < 50) begin step(); n++; end
            checks++;
            if (n != 8 || out_valid8 !== 1'b1 || out8 !== 8'hFE) begin
                errors++;
                $display("FAIL x8_mulhu: busy_cycles=%0d out_valid=%b out=%h expected 8/1/fe", n, out_valid8, out8);
            end
        end
`else
        func8 = F_MUL; in1_8 = 8'h0F; in2_8 = 8'h03;
        step();
        in_valid8 = 1'b0;
        checks++;
        if (out_valid8 !== 1'b1 || out8 !== 8'h00 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL x8_mul_reserved: out_valid=%b out=%h busy=%b expected 1/00/0", out_valid8, out8, busy8);
        end
`endif
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
`ifdef ALU_MC_MUL_EN
        test_mul();
        test_mul_abort();
`else
        test_mul_reserved();
`endif
        test_xlen8();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
